// File: rtl/arch_state_checker.sv
// Architectural-state checker. After each committed instruction it holds the
// core, walks registers x0..x(NCHK-1) and one DMEM word through the debug read
// ports, and compares them against a per-step expectation table. It reports
// the first differing entry and a final pass/fail verdict.
//
// Handshake: commit is a one-cycle pulse, accepted only in IDLE. stall is high
// in SCAN and MEM. A commit seen while stall=1 is an overrun and is dropped.
// exp_we writes the table on any cycle, independent of the FSM.
module arch_state_checker #(
    parameter int XLEN     = 32,
    parameter int NCHK     = 6,
    parameter int NSTEP    = 8,
    parameter int MEM_ADDR = 23,
    parameter int STEPW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit,
    input  logic [STEPW:0]   num_steps,
    input  logic             exp_we,
    input  logic [STEPW-1:0] exp_step,
    input  logic [4:0]       exp_idx,
    input  logic [XLEN-1:0]  exp_data,
    input  logic             exp_care,
    output logic [4:0]       dbg_raddr,
    input  logic [XLEN-1:0]  dbg_rdata,
    output logic [XLEN-1:0]  dbg_maddr,
    input  logic [XLEN-1:0]  dbg_mdata,
    output logic             stall,
    output logic             mismatch,
    output logic [STEPW-1:0] fail_step,
    output logic [4:0]       fail_idx,
    output logic [XLEN-1:0]  fail_got,
    output logic             overrun,
    output logic             done,
    output logic             pass
);

    localparam int             IDXW     = (NCHK > 1) ? $clog2(NCHK) : 1;
    localparam logic [5:0]     NCHK_W   = 6'(NCHK);
    localparam logic [4:0]     LAST_CNT = 5'(NCHK - 1);
    localparam logic [4:0]     MEM_IDX  = 5'(NCHK);
    localparam logic [STEPW:0] NSTEP_W  = (STEPW + 1)'(NSTEP);
    localparam logic [STEPW:0] ONE_W    = (STEPW + 1)'(1);

    typedef enum logic [1:0] {IDLE, SCAN, MEM, DONE} state_e;

    // Expectation table entries are {care, data}; not touched by rst.
    logic [XLEN:0] exp_reg_q [NSTEP][NCHK];
    logic [XLEN:0] exp_mem_q [NSTEP];

    state_e           state_q, state_d;
    logic [STEPW-1:0] step_q, step_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [STEPW:0]   steps_q, steps_d;
    logic             latched_q, latched_d;
    logic             mismatch_q, mismatch_d;
    logic [STEPW-1:0] fail_step_q, fail_step_d;
    logic [4:0]       fail_idx_q, fail_idx_d;
    logic [XLEN-1:0]  fail_got_q, fail_got_d;
    logic             overrun_q, overrun_d;

    logic             cmp_hit;
    logic [4:0]       cmp_idx;
    logic [XLEN-1:0]  cmp_got;
    logic [XLEN:0]    cur_reg;
    logic [XLEN:0]    cur_mem;
    logic             wr_step_ok;
    logic             wr_is_reg;
    logic             wr_is_mem;

    assign wr_step_ok = ({1'b0, exp_step} < NSTEP_W);
    assign wr_is_reg  = ({1'b0, exp_idx} < NCHK_W);
    assign wr_is_mem  = ({1'b0, exp_idx} == NCHK_W);
    assign cur_reg    = exp_reg_q[step_q][cnt_q[IDXW-1:0]];
    assign cur_mem    = exp_mem_q[step_q];

    // Table write port; indices beyond the DMEM slot are dropped.
    always_ff @(posedge clk) begin
        if (exp_we && wr_step_ok) begin
            if (wr_is_reg) begin
                exp_reg_q[exp_step][exp_idx[IDXW-1:0]] <= {exp_care, exp_data};
            end else if (wr_is_mem) begin
                exp_mem_q[exp_step] <= {exp_care, exp_data};
            end
        end
    end

    // FSM and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            steps_q     <= '0;
            latched_q   <= 1'b0;
            mismatch_q  <= 1'b0;
            fail_step_q <= '0;
            fail_idx_q  <= '0;
            fail_got_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            steps_q     <= steps_d;
            latched_q   <= latched_d;
            mismatch_q  <= mismatch_d;
            fail_step_q <= fail_step_d;
            fail_idx_q  <= fail_idx_d;
            fail_got_q  <= fail_got_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state, per-entry compare and first-mismatch capture.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        steps_d     = steps_q;
        latched_d   = latched_q;
        mismatch_d  = mismatch_q;
        fail_step_d = fail_step_q;
        fail_idx_d  = fail_idx_q;
        fail_got_d  = fail_got_q;
        overrun_d   = overrun_q;
        cmp_hit     = 1'b0;
        cmp_idx     = '0;
        cmp_got     = '0;

        case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    // Step count is frozen at the first commit; 0 means 1.
                    if (!latched_q) begin
                        latched_d = 1'b1;
                        if (num_steps == '0) begin
                            steps_d = ONE_W;
                        end else if (num_steps > NSTEP_W) begin
                            steps_d = NSTEP_W;
                        end else begin
                            steps_d = num_steps;
                        end
                    end
                end
            end
            SCAN: begin
                if (commit) begin
                    overrun_d = 1'b1;
                end
                if (cur_reg[XLEN] && (dbg_rdata != cur_reg[XLEN-1:0])) begin
                    cmp_hit = 1'b1;
                    cmp_idx = cnt_q;
                    cmp_got = dbg_rdata;
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = MEM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            MEM: begin
                if (commit) begin
                    overrun_d = 1'b1;
                end
                if (cur_mem[XLEN] && (dbg_mdata != cur_mem[XLEN-1:0])) begin
                    cmp_hit = 1'b1;
                    cmp_idx = MEM_IDX;
                    cmp_got = dbg_mdata;
                end
                if ({1'b0, step_q} == (steps_q - ONE_W)) begin
                    state_d = DONE;
                end else begin
                    step_d  = step_q + 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Only the first differing entry is recorded.
        if (cmp_hit && !mismatch_q) begin
            fail_step_d = step_q;
            fail_idx_d  = cmp_idx;
            fail_got_d  = cmp_got;
        end
        mismatch_d = mismatch_q | cmp_hit;
    end

    assign stall     = (state_q == SCAN) || (state_q == MEM);
    assign dbg_raddr = (state_q == SCAN) ? cnt_q : 5'd0;
    assign dbg_maddr = XLEN'(MEM_ADDR);
    assign done      = (state_q == DONE);
    assign pass      = done & ~mismatch_q & ~overrun_q;
    assign mismatch  = mismatch_q;
    assign fail_step = fail_step_q;
    assign fail_idx  = fail_idx_q;
    assign fail_got  = fail_got_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_arch_state_checker.sv
// Bench for arch_state_checker: a tiny register-file/DMEM core model feeds the
// debug ports, a transaction-level reference model predicts the outputs, and a
// compare process checks them every cycle. Directed scenarios add literal
// expectations that pin the reference model.
module tb_arch_state_checker;

    localparam int NCHK = 6;

    typedef struct packed {
        logic        found;
        logic [4:0]  idx;
        logic [31:0] got;
    } diff_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit = 1'b0;
    logic [3:0]  num_steps = 4'd8;
    logic        exp_we = 1'b0;
    logic [2:0]  exp_step = '0;
    logic [4:0]  exp_idx = '0;
    logic [31:0] exp_data = '0;
    logic        exp_care = 1'b0;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    logic [31:0] dbg_maddr;
    logic [31:0] dbg_mdata;
    logic        stall, mismatch, overrun, done, pass;
    logic [2:0]  fail_step;
    logic [4:0]  fail_idx;
    logic [31:0] fail_got;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    // Core state seen through the debug ports.
    logic [31:0] rf [0:31];
    logic [31:0] dm;

    // Bench copy of the expectation table.
    logic [31:0] t_data [0:7][0:6];
    logic        t_care [0:7][0:6];

    // Reference model state.
    int          m_busy = 0;
    logic [2:0]  m_step = '0;
    logic        m_latched = 1'b0;
    logic [3:0]  m_steps = '0;
    logic        m_mis = 1'b0;
    logic [2:0]  m_fs = '0;
    logic [4:0]  m_fi = '0;
    logic [31:0] m_fg = '0;
    logic        m_ovr = 1'b0;
    logic        m_done = 1'b0;
    diff_t       cur_diff;

    arch_state_checker #(
        .XLEN(32), .NCHK(NCHK), .NSTEP(8), .MEM_ADDR(23), .STEPW(3)
    ) dut (
        .clk(clk), .rst(rst), .commit(commit), .num_steps(num_steps),
        .exp_we(exp_we), .exp_step(exp_step), .exp_idx(exp_idx),
        .exp_data(exp_data), .exp_care(exp_care),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .dbg_maddr(dbg_maddr), .dbg_mdata(dbg_mdata),
        .stall(stall), .mismatch(mismatch), .fail_step(fail_step),
        .fail_idx(fail_idx), .fail_got(fail_got), .overrun(overrun),
        .done(done), .pass(pass)
    );

    // Clock.
    always #5 clk = ~clk;

    assign dbg_rdata = rf[dbg_raddr];
    assign dbg_mdata = (dbg_maddr == 32'd23) ? dm : 32'hbad0_bad0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d (0x%h) expected=%0d (0x%h) t=%0t", name, got, got, exp, exp, $time);
        end
    endtask

    // First cared entry of step s that differs from the current core state.
    function automatic diff_t first_diff(input logic [2:0] s);
        diff_t d;
        d = '0;
        for (int i = 0; i <= NCHK; i++) begin
            logic [31:0] obs;
            obs = (i < NCHK) ? rf[i] : dm;
            if (!d.found && t_care[s][i] && (obs != t_data[s][i])) begin
                d.found = 1'b1;
                d.idx   = 5'(i);
                d.got   = obs;
            end
        end
        return d;
    endfunction

    always_comb cur_diff = first_diff(m_step);

    // Reference model: each accepted commit occupies NCHK+1 cycles, then the
    // whole step is judged at once against the table.
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_step <= '0; m_latched <= 1'b0; m_steps <= '0;
            m_mis <= 1'b0; m_fs <= '0; m_fi <= '0; m_fg <= '0;
            m_ovr <= 1'b0; m_done <= 1'b0;
        end else if (m_busy > 0) begin
            if (commit) m_ovr <= 1'b1;
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
                if (cur_diff.found && !m_mis) begin
                    m_mis <= 1'b1; m_fs <= m_step; m_fi <= cur_diff.idx; m_fg <= cur_diff.got;
                end
                if (int'(m_step) == int'(m_steps) - 1) m_done <= 1'b1;
                else m_step <= m_step + 3'd1;
            end
        end else if (commit && !m_done) begin
            m_busy <= NCHK + 1;
            if (!m_latched) begin
                m_latched <= 1'b1;
                m_steps <= (num_steps == 4'd0) ? 4'd1 : num_steps;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall), 32'(m_busy > 0));
            check("done", 32'(done), 32'(m_done));
            check("pass", 32'(pass), 32'(m_done && !m_mis && !m_ovr));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("dbg_raddr", 32'(dbg_raddr), (m_busy >= 2) ? 32'(NCHK + 1 - m_busy) : 32'd0);
            check("dbg_maddr", dbg_maddr, 32'd23);
            if (m_busy == 0) begin
                check("mismatch", 32'(mismatch), 32'(m_mis));
                check("fail_step", 32'(fail_step), 32'(m_fs));
                check("fail_idx", 32'(fail_idx), 32'(m_fi));
                check("fail_got", fail_got, m_fg);
            end
        end
    end

    task automatic core_reset();
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[0] = 32'd57;
        dm = 32'd0;
    endtask

    // Architectural effect of program instruction k (lui/addi/add/sw/lw).
    task automatic apply_effect(input int k);
        case (k)
            0: rf[1] = 32'd16;            // lui-style load of x1
            1: rf[2] = 32'd21;            // addi x2
            2: rf[4] = 32'd13;            // addi x4
            3: rf[3] = rf[2];             // addi x3, x2, 0
            4: dm = rf[1];                // sw x1 -> DMEM[23]
            5: rf[5] = rf[0] + rf[4];     // add x5, x0, x4
            6: rf[3] = dm;                // lw x3 <- DMEM[23]
            7: rf[4] = rf[4] + 32'd0;     // addi x4, x4, 0
            default: ;
        endcase
    endtask

    task automatic write_entry(input int s, input int idx, input logic [31:0] data, input logic care);
        @(negedge clk);
        exp_we = 1'b1; exp_step = 3'(s); exp_idx = 5'(idx); exp_data = data; exp_care = care;
        if (idx <= NCHK) begin
            t_data[s][idx] = data;
            t_care[s][idx] = care;
        end
        @(posedge clk);
        #1 exp_we = 1'b0;
    endtask

    task automatic load_table();
        core_reset();
        for (int s = 0; s < 8; s++) begin
            apply_effect(s);
            for (int i = 0; i < NCHK; i++) write_entry(s, i, rf[i], 1'b1);
            write_entry(s, NCHK, dm, 1'b1);
        end
        // Out-of-range entry index: must have no effect.
        write_entry(0, 7, 32'h0000_1234, 1'b1);
        core_reset();
    endtask

    task automatic raw_commit();
        @(negedge clk);
        commit = 1'b1;
        @(posedge clk);
        #1 commit = 1'b0;
    endtask

    task automatic commit_step(input int k);
        raw_commit();
        apply_effect(k);
    endtask

    // Counts stall cycles until the checker releases the core.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!stall) return;
            cnt++;
        end
        check("wait_idle_timeout", 32'(cnt), 32'd0);
    endtask

    task automatic run_steps(input int first, input int last, input logic chk_stall);
        int n;
        for (int k = first; k <= last; k++) begin
            commit_step(k);
            wait_idle(n);
            if (chk_stall) check("stall_cycles", 32'(n), 32'd7);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        core_reset();
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_raddr"}, 32'(dbg_raddr), 32'd0);
        check({tag, "_fstep"}, 32'(fail_step), 32'd0);
        check({tag, "_fidx"}, 32'(fail_idx), 32'd0);
        check({tag, "_fgot"}, fail_got, 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] keep;
        core_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        check_reset_values("rst0");

        // Golden run of the 8-step program.
        load_table();
        run_steps(0, 7, 1'b1);
        check("t1_done", 32'(done), 32'd1);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_mismatch", 32'(mismatch), 32'd0);
        check("t1_x5", rf[5], 32'd70);
        check("t1_dm", dm, 32'd16);

        // Step 5 expects x5=71.
        do_reset();
        write_entry(5, 5, 32'd71, 1'b1);
        run_steps(0, 7, 1'b0);
        check("t2_mismatch", 32'(mismatch), 32'd1);
        check("t2_fail_step", 32'(fail_step), 32'd5);
        check("t2_fail_idx", 32'(fail_idx), 32'd5);
        check("t2_fail_got", fail_got, 32'd70);
        check("t2_pass", 32'(pass), 32'd0);
        check("t2_done", 32'(done), 32'd1);
        write_entry(5, 5, 32'd70, 1'b1);

        // Step 2: all entries don't-care with corrupted data.
        do_reset();
        for (int i = 0; i <= NCHK; i++) write_entry(2, i, 32'hdead_0000 + 32'(i), 1'b0);
        run_steps(0, 7, 1'b0);
        check("t3_pass", 32'(pass), 32'd1);
        core_reset();
        for (int s = 0; s <= 2; s++) apply_effect(s);
        for (int i = 0; i < NCHK; i++) write_entry(2, i, rf[i], 1'b1);
        write_entry(2, NCHK, dm, 1'b1);

        // Two commits two cycles apart: second one is an overrun.
        do_reset();
        commit_step(0);
        @(negedge clk);
        raw_commit();
        wait_idle(n);
        check("t4_overrun_now", 32'(overrun), 32'd1);
        run_steps(1, 6, 1'b0);
        check("t4_not_done_early", 32'(done), 32'd0);
        run_steps(7, 7, 1'b0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_pass", 32'(pass), 32'd0);
        check("t4_mismatch", 32'(mismatch), 32'd0);

        // Reset in the middle of step 3's scan, then a rerun without reload.
        do_reset();
        run_steps(0, 2, 1'b0);
        commit_step(3);
        repeat (2) @(negedge clk);
        do_reset();
        check_reset_values("t5");
        run_steps(0, 7, 1'b0);
        check("t5_pass", 32'(pass), 32'd1);

        // num_steps=1: done after 8 cycles; later commits are ignored.
        do_reset();
        num_steps = 4'd1;
        commit_step(0);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin n = i; break; end
        end
        check("t6_done_cycles", 32'(n), 32'd8);
        raw_commit();
        repeat (2) @(negedge clk);
        raw_commit();
        repeat (2) @(negedge clk);
        check("t6_overrun", 32'(overrun), 32'd0);
        check("t6_pass", 32'(pass), 32'd1);

        // Table write in the commit cycle is seen by that scan.
        do_reset();
        keep = t_data[0][1];
        @(negedge clk);
        commit = 1'b1;
        exp_we = 1'b1; exp_step = 3'd0; exp_idx = 5'd1; exp_data = 32'd99; exp_care = 1'b1;
        t_data[0][1] = 32'd99; t_care[0][1] = 1'b1;
        @(posedge clk);
        #1 commit = 1'b0; exp_we = 1'b0;
        apply_effect(0);
        wait_idle(n);
        check("t7_mismatch", 32'(mismatch), 32'd1);
        check("t7_fail_idx", 32'(fail_idx), 32'd1);
        check("t7_fail_got", fail_got, 32'd16);
        check("t7_done", 32'(done), 32'd1);
        write_entry(0, 1, keep, 1'b1);
        num_steps = 4'd8;

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
